// File: rtl/featuremap_pad_writer_if.sv
// featuremap_pad_writer_if: pixel stream in and FIFO write port out.
// master = the pad writer, slave = upstream source / FIFO side.
// The optional `last` signal exists only when FEATUREMAP_PAD_WRITER_LAST_EN is defined.
interface featuremap_pad_writer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [3*DATA_WIDTH-1:0] pix_in;
  logic                    pix_valid;
  logic                    pix_ready;
  logic                    fifo_full;
  logic [3*DATA_WIDTH-1:0] data_out;
  logic                    wrreq;
`ifdef FEATUREMAP_PAD_WRITER_LAST_EN
  logic                    last;

  modport master (
    input  pix_in, pix_valid, fifo_full,
    output pix_ready, data_out, wrreq, last
  );
  modport slave (
    output pix_in, pix_valid, fifo_full,
    input  pix_ready, data_out, wrreq, last
  );
`else
  modport master (
    input  pix_in, pix_valid, fifo_full,
    output pix_ready, data_out, wrreq
  );
  modport slave (
    output pix_in, pix_valid, fifo_full,
    input  pix_ready, data_out, wrreq
  );
`endif
endinterface

// File: rtl/featuremap_pad_writer.sv
// featuremap_pad_writer: wraps an unpadded WIDTH x HEIGHT {B,G,R} frame in a
// one-word zero border and writes the (WIDTH+2) x (HEIGHT+2) result to the
// conv2d input FIFO, one word per cycle at peak.
// Optional feature: define FEATUREMAP_PAD_WRITER_LAST_EN to add a `last` flag
// marking the final word of each frame.
module featuremap_pad_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 112,
  parameter int HEIGHT     = 112
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  featuremap_pad_writer_if.master bus
);

  localparam int COL_W = $clog2(WIDTH + 2);
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST     = COL_W'(WIDTH + 1);
  localparam logic [COL_W-1:0] COL_PIX_LAST = COL_W'(WIDTH);
  localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, TOP, LEFT, PIX, RIGHT, BOTTOM, FIN} state_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             zero_state;
  logic             emit;

  // pix_ready depends only on state and FIFO space, never on pix_valid
  assign bus.pix_ready = (state == PIX) && !bus.fifo_full;

  // Decide whether a word leaves this cycle; border states emit zeros freely
  always_comb begin
    zero_state = (state == TOP) || (state == LEFT) ||
                 (state == RIGHT) || (state == BOTTOM);
    emit       = 1'b0;
    if (zero_state) begin
      emit = !bus.fifo_full;
    end else if (state == PIX) begin
      emit = bus.pix_ready && bus.pix_valid;
    end
  end

  // Frame FSM, padded-position counters and the registered FIFO write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      bus.wrreq    <= 1'b0;
      bus.data_out <= '0;
    end else begin
      bus.wrreq <= emit;
      done      <= 1'b0;
      if (emit) begin
        bus.data_out <= zero_state ? '0 : bus.pix_in;
        col          <= (col == COL_LAST) ? '0 : col + 1'b1;
      end
      case (state)
        IDLE: begin
          // done high means IDLE was only just entered; that start is dropped
          if (start && !done) begin
            state <= TOP;
            busy  <= 1'b1;
            col   <= '0;
            row   <= '0;
          end
        end
        TOP: begin
          if (emit && col == COL_LAST) state <= LEFT;
        end
        LEFT: begin
          if (emit) state <= PIX;
        end
        PIX: begin
          if (emit && col == COL_PIX_LAST) state <= RIGHT;
        end
        RIGHT: begin
          if (emit) begin
            if (row == ROW_LAST) begin
              state <= BOTTOM;
            end else begin
              row   <= row + 1'b1;
              state <= LEFT;
            end
          end
        end
        BOTTOM: begin
          if (emit && col == COL_LAST) state <= FIN;
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FEATUREMAP_PAD_WRITER_LAST_EN
  // Flag the final bottom-border word, registered in step with wrreq
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.last <= 1'b0;
    end else begin
      bus.last <= emit && (state == BOTTOM) && (col == COL_LAST);
    end
  end
`endif

endmodule

// File: doc/featuremap_pad_writer.md
# featuremap_pad_writer

Producer side of the 3-channel pixel FIFO feeding the `featuremap_conv2d_*` filter blocks. Accepts an unpadded WIDTH×HEIGHT RGB frame from upstream over valid/ready and writes a zero-bordered (WIDTH+2)×(HEIGHT+2) stream into the FIFO. Output word packing matches the consumer side: B in [95:64], G in [63:32], R in [31:0]. One frame is produced per `start` pulse.

## Interface
- `DATA_WIDTH`, 32: width of one channel sample (IEEE-754 single).
- `WIDTH`, 112: unpadded columns per row.
- `HEIGHT`, 112: unpadded rows per frame.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a frame when idle.
- `pix_in`  in  DATA_WIDTH*3  unpadded pixel, packed {B,G,R}.
- `pix_valid`  in  1  `pix_in` is valid.
- `pix_ready`  out  1  block accepts `pix_in` this cycle.
- `fifo_full`  in  1  FIFO almost-full: asserted when ≤1 slot is free.
- `data_out`  out  DATA_WIDTH*3  word written to the FIFO.
- `wrreq`  out  1  FIFO write strobe, one word per high cycle.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse after the last word is written.

## Operation
- FSM states: IDLE, TOP, LEFT, PIX, RIGHT, BOTTOM, FIN.
- IDLE: `busy`=0. `start`=1 -> TOP with col=0 and row=0.
- TOP: emits WIDTH+2 zero words (padded row 0), then -> LEFT.
- LEFT: emits one zero word, then -> PIX.
- PIX: emits WIDTH upstream pixels in arrival order, then -> RIGHT.
- RIGHT: emits one zero word. If fewer than HEIGHT image rows are done -> LEFT, else -> BOTTOM.
- BOTTOM: emits WIDTH+2 zero words, then -> FIN.
- FIN: `done`=1 for one cycle, then -> IDLE.
- Emit condition:
  - In zero states, a word is emitted in any cycle with `fifo_full`=0.
  - In PIX, a word is emitted only when `pix_valid`=1, `pix_ready`=1 and `fifo_full`=0.
- `pix_ready` = (state==PIX) && !`fifo_full`. This is combinational and independent of `pix_valid`.
- Zero word: all bits 0, i.e. +0.0 in each channel.
- Counters:
  - col counts 0..WIDTH+1; row counts 0..HEIGHT-1. Width is $clog2(WIDTH+2) and $clog2(HEIGHT) bits respectively.
  - col advances only on emit and wraps to 0 at the end of each padded row.
- Total words per frame: (WIDTH+2)*(HEIGHT+2), i.e. 12996 at the defaults.
- `start` while `busy`=1 is ignored; the current frame is not restarted.
- `start` in the same cycle as `done` is ignored; a new frame requires `start` while in IDLE.
- Upstream pixels presented outside PIX are not consumed (`pix_ready`=0).

## Timing
- Values after reset: `wrreq`=0, `data_out`=0, `done`=0, `busy`=0, `pix_ready`=0; state=IDLE; counters cleared.
- `data_out` and `wrreq` are registered. A word emitted in cycle t appears with `wrreq`=1 in cycle t+1.
- `fifo_full` has almost-full semantics, which covers the one registered word in flight. The FIFO is never written while truly full.
- Start-to-first-write latency: `start` in cycle t gives the TOP emit in cycle t+1 and `wrreq` high in cycle t+2, given `fifo_full`=0.
- Peak throughput is one word per cycle with no bubbles at state transitions.
- `busy` goes high the cycle after `start` and goes low the cycle after FIN.
- `done` is high in the cycle after the final `wrreq`.
- `fifo_full` held high stalls all emission, with counters and state frozen. Emission resumes the cycle it deasserts.
- Reset asserted mid-frame: immediate return to the reset values above. A partial frame may remain in the FIFO; clearing it is the owner's job.

## Configuration
- `FEATUREMAP_PAD_WRITER_LAST_EN` defined:
  - Adds output port `last` (1 bit), registered alongside `wrreq`.
  - `last`=1 only on the final BOTTOM word of the frame; 0 after reset.
- Undefined: the `last` port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=4, HEIGHT=3, `fifo_full`=0, `pix_valid` always 1 with an incrementing pattern:
  - Exactly 30 `wrreq` pulses in 30 consecutive cycles.
  - Words 0–5 and 24–29 are zero; each of the three middle rows is 0, p, p, p, p, 0 with p in order.
  - `done` is high one cycle after word 29.
- Same setup with `pix_valid` toggling every other cycle:
  - `wrreq` gaps appear only in PIX.
  - Output content is identical to the previous scenario.
- `fifo_full` held high for 5 cycles mid-PIX:
  - No `wrreq` and `pix_ready`=0 during the hold.
  - No word is lost or duplicated; the total is still 30.
- `start` pulsed again at word 10, and again in the `done` cycle:
  - The frame completes with 30 words.
  - No second frame starts.
- `rst` asserted at word 17:
  - Outputs go to their reset values immediately.
  - A new `start` then produces a full, correct 30-word frame.
- Defaults (112×112) with `FEATUREMAP_PAD_WRITER_LAST_EN` defined:
  - 12996 words are written.
  - `last` is high only on word 12995.
